// File: rtl/bcd_to_bin_seq_if.sv
// Start/busy/done handshake bundle for the sequential BCD-to-binary converter.
// The master issues requests; the slave is the converter itself.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output start,
    output bcd_in,
    input  busy,
    input  done,
    input  bin_out,
    input  err
  );

  modport slave (
    input  start,
    input  bcd_in,
    output busy,
    output done,
    output bin_out,
    output err
  );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble, one shift per clock).
// Optional macro BCD_DIGIT_CHECK_EN flags digits above 9 and forces bin_out to 0.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic             clk,
  input  logic             reset,
  bcd_to_bin_seq_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  // The binary field is as wide as the number of shifts so the first bit shifted
  // out of the BCD field lands exactly at bit 0 after the final shift.
  localparam int WORK_W = 2 * BCD_W;
  localparam int CNT_W  = $clog2(BCD_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BCD_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_r;
  logic [WORK_W-1:0]   work_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                busy_r;
  logic                done_r;
  logic [BIN_W-1:0]    bin_r;
  logic                err_r;
  logic [WORK_W-1:0]   shift_s;
`ifdef BCD_DIGIT_CHECK_EN
  logic                bad_r;
`endif

  function automatic logic [WORK_W-1:0] shift_correct(input logic [WORK_W-1:0] w);
    logic [WORK_W-1:0] s;
    s = {1'b0, w[WORK_W-1:1]};
    for (int d = 0; d < DIGITS; d++) begin
      if (s[BCD_W + 4*d +: 4] >= 4'd8) begin
        s[BCD_W + 4*d +: 4] = s[BCD_W + 4*d +: 4] - 4'd3;
      end else begin
        s[BCD_W + 4*d +: 4] = s[BCD_W + 4*d +: 4];
      end
    end
    return s;
  endfunction

`ifdef BCD_DIGIT_CHECK_EN
  function automatic logic has_bad_digit(input logic [BCD_W-1:0] b);
    logic bad;
    bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (b[4*d +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction
`endif

  // Next work-register value for one shift-and-correct iteration.
  always_comb begin
    shift_s = shift_correct(work_r);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      work_r  <= '0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      bin_r   <= '0;
      err_r   <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      bad_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            work_r  <= {bus.bcd_in, {BCD_W{1'b0}}};
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_SHIFT;
`ifdef BCD_DIGIT_CHECK_EN
            bad_r   <= has_bad_digit(bus.bcd_in);
`endif
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          work_r <= shift_s;
          cnt_r  <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
            bin_r   <= bad_r ? {BIN_W{1'b0}} : shift_s[BIN_W-1:0];
            err_r   <= bad_r;
`else
            bin_r   <= shift_s[BIN_W-1:0];
            err_r   <= 1'b0;
`endif
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.bin_out = bin_r;
  assign bus.err     = err_r;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq; honours BCD_DIGIT_CHECK_EN.
module tb_bcd_to_bin_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  bcd_to_bin_seq_if #(.DIGITS(4), .BIN_W(14)) bus ();

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a conversion and follow it: edges counts the start edge as 1.
  task automatic convert(input logic [15:0] v, output int edges, output int busy_cyc,
                         output int done_cnt);
    @(negedge clk);
    bus.bcd_in = v;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    edges    = 1;
    busy_cyc = bus.busy ? 1 : 0;
    done_cnt = 0;
    while (bus.done !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.done === 1'b1) done_cnt++;
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.done === 1'b1) done_cnt++;
    end
  endtask

  int edges, busy_cyc, done_cnt, last_done, n_done;

  initial begin
    bus.start  = 1'b0;
    bus.bcd_in = 16'h0000;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_bin",  32'(bus.bin_out), 32'd0);
    check("rst_err",  32'(bus.err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Maximum value, latency and busy length
    convert(16'h9999, edges, busy_cyc, done_cnt);
    check("max_edges", 32'(edges), 32'd17);
    check("max_busy",  32'(busy_cyc), 32'd17);
    check("max_ndone", 32'(done_cnt), 32'd1);
    check("max_bin",   32'(bus.bin_out), 32'h270F);
    check("max_err",   32'(bus.err), 32'd0);

    convert(16'h0000, edges, busy_cyc, done_cnt);
    check("zero_bin",   32'(bus.bin_out), 32'h0000);
    check("zero_ndone", 32'(done_cnt), 32'd1);
    convert(16'h1234, edges, busy_cyc, done_cnt);
    check("v1234_bin",   32'(bus.bin_out), 32'h04D2);
    check("v1234_ndone", 32'(done_cnt), 32'd1);
    convert(16'h0001, edges, busy_cyc, done_cnt);
    check("one_bin",   32'(bus.bin_out), 32'h0001);
    check("one_ndone", 32'(done_cnt), 32'd1);

    // start re-pulsed at E5 with a different bcd_in must be ignored
    @(negedge clk);
    bus.bcd_in = 16'h0500;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    edges = 1;
    done_cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      edges++;
    end
    @(negedge clk);
    bus.bcd_in = 16'h9999;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    edges++;
    while (bus.done !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("ign_edges", 32'(edges), 32'd17);
    check("ign_bin",   32'(bus.bin_out), 32'h01F4);
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
    end
    check("ign_no_second", 32'(done_cnt), 32'd0);

    // start held high: back-to-back conversions every 18 cycles
    @(negedge clk);
    bus.bcd_in = 16'h0042;
    bus.start  = 1'b1;
    last_done = -1;
    n_done = 0;
    for (int e = 1; e <= 100 && n_done < 3; e++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        check("b2b_bin", 32'(bus.bin_out), 32'h002A);
        if (last_done >= 0) check("b2b_period", 32'(e - last_done), 32'd18);
        last_done = e;
        n_done++;
      end
    end
    check("b2b_count", 32'(n_done), 32'd3);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(posedge clk);

    // Reset at E8 of a conversion: immediate clear, no done pulse
    @(negedge clk);
    bus.bcd_in = 16'h7777;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_bin",  32'(bus.bin_out), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_cnt++;
    end
    check("mid_rst_nodone", 32'(done_cnt), 32'd0);
    convert(16'h0010, edges, busy_cyc, done_cnt);
    check("after_rst_bin", 32'(bus.bin_out), 32'h000A);

    // Invalid digit handling
    convert(16'h0A05, edges, busy_cyc, done_cnt);
    check("bad_edges", 32'(edges), 32'd17);
    check("bad_ndone", 32'(done_cnt), 32'd1);
`ifdef BCD_DIGIT_CHECK_EN
    check("bad_err", 32'(bus.err), 32'd1);
    check("bad_bin", 32'(bus.bin_out), 32'd0);
`else
    check("bad_err", 32'(bus.err), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
